// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector with Mealy match pulse, match counter and run sequencing.
// Optional no-match watchdog is compiled in when the TIMEOUT_EN macro is defined.
module seq_detect_ctrl #(
  parameter int PAT_W   = 4,
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 16,
  parameter int TMO_LIM = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_wr,
  input  logic [PAT_W-1:0]         cfg_pattern,
  input  logic [$clog2(PAT_W):0]   cfg_len,
  input  logic                     cfg_overlap,
  input  logic [CNT_W-1:0]         cfg_target,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     in,
  input  logic                     in_valid,
  output logic                     match,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout
);

  localparam int LEN_W = $clog2(PAT_W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r, state_nx_s;
  logic [PAT_W-1:0]   pattern_r;
  logic [LEN_W-1:0]   len_r;
  logic               overlap_r;
  logic [CNT_W-1:0]   target_r;
  logic [PAT_W-2:0]   hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
  logic               done_r;

  logic [PAT_W-1:0]   window_s;
  logic [PAT_W-1:0]   mask_s;
  logic [LEN_W-1:0]   len_m1_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               len_ok_s;
  logic               consume_s;
  logic               match_s;
  logic               go_s;
  logic               tgt_hit_s;
  logic               tmo_hit_s;

  assign window_s  = {hist_r, in};
  assign len_m1_s  = len_r - LEN_W'(1);
  assign len_ok_s  = (len_r != '0) && (len_r <= LEN_W'(PAT_W));
  assign consume_s = (state_r == RUN) && in_valid && !abort;
  assign match_s   = consume_s && (fill_r >= len_m1_s) &&
                     (((window_s ^ pattern_r) & mask_s) == '0);
  assign cnt_inc_s = cnt_r + CNT_W'(1);
  assign tgt_hit_s = match_s && (target_r != '0) && (cnt_inc_s == target_r);
  // Abort dominates start; a re-arm from DONE does not re-check the length.
  assign go_s      = start && !abort &&
                     (((state_r == IDLE) && len_ok_s) || (state_r == DONE));

  // Compare mask: only the low len bits of the window take part in a match.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < PAT_W; i++) begin
      if (i < int'(len_r)) begin
        mask_s[i] = 1'b1;
      end else begin
        mask_s[i] = 1'b0;
      end
    end
  end

  // Next-state logic for the run controller.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (go_s) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx_s = IDLE;
        end else if (tgt_hit_s || tmo_hit_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (abort) begin
          state_nx_s = IDLE;
        end else if (go_s) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, configuration, history and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      pattern_r <= '0;
      len_r     <= '0;
      overlap_r <= 1'b0;
      target_r  <= '0;
      hist_r    <= '0;
      fill_r    <= '0;
      cnt_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == RUN);
      done_r  <= (state_nx_s == DONE);
      if (cfg_wr && (state_r != RUN)) begin
        pattern_r <= cfg_pattern;
        len_r     <= cfg_len;
        overlap_r <= cfg_overlap;
        target_r  <= cfg_target;
      end
      if (go_s) begin
        hist_r <= '0;
        fill_r <= '0;
        cnt_r  <= '0;
      end else if (consume_s) begin
        hist_r <= window_s[PAT_W-2:0];
        // Non-overlap restarts the fill so consecutive matches never share bits.
        if (match_s && !overlap_r) begin
          fill_r <= '0;
        end else if (fill_r != LEN_W'(PAT_W)) begin
          fill_r <= fill_r + LEN_W'(1);
        end
        if (match_s) begin
          cnt_r <= cnt_inc_s;
        end
      end
    end
  end

`ifdef TIMEOUT_EN
  logic [TMO_W-1:0] wdog_r;
  logic [TMO_W-1:0] wdog_inc_s;
  logic             timeout_r;

  assign wdog_inc_s = wdog_r + TMO_W'(1);
  assign tmo_hit_s  = consume_s && !match_s && (wdog_inc_s == TMO_W'(TMO_LIM));

  // No-match watchdog; the timeout flag lives only as long as the DONE it caused.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_r    <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (go_s || match_s) begin
        wdog_r <= '0;
      end else if (consume_s) begin
        wdog_r <= wdog_inc_s;
      end
      timeout_r <= (state_nx_s == DONE) &&
                   (tmo_hit_s || ((state_r == DONE) && timeout_r));
    end
  end

  assign timeout = timeout_r;
`else
  logic unused_tmo_s;

  assign unused_tmo_s = (TMO_LIM > TMO_W);
  assign tmo_hit_s    = 1'b0;
  assign timeout      = 1'b0;
`endif

  assign match     = match_s;
  assign match_cnt = cnt_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: stimulus queues expected match cycles, a monitor checks pulses.
module tb_seq_detect_ctrl;

`ifdef TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_wr = 1'b0;
  logic [3:0] cfg_pattern = 4'd0;
  logic [2:0] cfg_len = 3'd0;
  logic       cfg_overlap = 1'b0;
  logic [7:0] cfg_target = 8'd0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       din = 1'b0;
  logic       in_valid = 1'b0;
  logic       match;
  logic [7:0] match_cnt;
  logic       busy;
  logic       done;
  logic       timeout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_q[$];

  seq_detect_ctrl #(.PAT_W(4), .CNT_W(8), .TMO_W(16), .TMO_LIM(8)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .start(start), .abort(abort),
    .in(din), .in_valid(in_valid), .match(match), .match_cnt(match_cnt), .busy(busy),
    .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every match pulse must line up with the next expected cycle.
  always @(negedge clk) begin
    if (match) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL match_unexpected cycle=%0d actual=1 required=0", cyc);
      end else if (exp_q[0] != cyc) begin
        failures++;
        $display("FAIL match_cycle actual=%0d required=%0d", cyc, exp_q[0]);
        void'(exp_q.pop_front());
      end else begin
        void'(exp_q.pop_front());
      end
    end else if (exp_q.size() > 0 && exp_q[0] == cyc) begin
      checks++;
      failures++;
      $display("FAIL match_missing cycle=%0d actual=0 required=1", cyc);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish actual=running required=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic clr();
    din = 1'b0; in_valid = 1'b0; start = 1'b0; abort = 1'b0; cfg_wr = 1'b0;
  endtask

  task automatic tick(input logic b, input logic v, input logic em);
    @(posedge clk); #1;
    clr();
    din = b; in_valid = v;
    if (em) exp_q.push_back(cyc);
  endtask

  task automatic settle();
    @(posedge clk); #1;
    clr();
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    clr();
    start = 1'b1;
  endtask

  task automatic do_abort();
    @(posedge clk); #1;
    clr();
    abort = 1'b1;
  endtask

  task automatic cfg(input logic [3:0] p, input logic [2:0] l, input logic ov, input logic [7:0] t);
    @(posedge clk); #1;
    clr();
    cfg_wr = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_target = t;
  endtask

  // Bits are sent from index n-1 down to 0; em marks which bits must produce a match.
  task automatic stream(input logic [15:0] bits, input int n, input logic [15:0] em);
    for (int i = n - 1; i >= 0; i--) tick(bits[i], 1'b1, em[i]);
  endtask

  initial begin
    clr();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_cnt", match_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_match", match, 0);

    // Non-overlapping 1001 over 1001001
    cfg(4'b1001, 3'd4, 1'b0, 8'd0);
    do_start(); settle();
    chk("t1_busy", busy, 1);
    chk("t1_cnt0", match_cnt, 0);
    stream(16'b1001001, 7, 16'b0001000); settle();
    chk("t1_cnt", match_cnt, 1);

    // Overlapping mode
    do_abort(); settle();
    chk("t2_idle", busy, 0);
    cfg(4'b1001, 3'd4, 1'b1, 8'd0);
    do_start(); settle();
    chk("t2_cnt0", match_cnt, 0);
    stream(16'b1001001, 7, 16'b0001001); settle();
    chk("t2_cnt", match_cnt, 2);

    // Target of two ends the run; DONE ignores input; start re-arms
    do_abort();
    cfg(4'b1001, 3'd4, 1'b1, 8'd2);
    do_start();
    stream(16'b1001001, 7, 16'b0001001); settle();
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    chk("t3_cnt", match_cnt, 2);
    stream(16'b1001, 4, 16'b0000); settle();
    chk("t3_cnt_hold", match_cnt, 2);
    do_start(); settle();
    chk("t3_rearm_busy", busy, 1);
    chk("t3_rearm_done", done, 0);
    chk("t3_rearm_cnt", match_cnt, 0);

    // Gaps with in_valid low are not consumed
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    settle();
    chk("t4_cnt", match_cnt, 1);

    // cfg_wr in RUN ignored; abort beats the final matching bit
    cfg(4'b1111, 3'd4, 1'b0, 8'd0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    clr();
    din = 1'b1; in_valid = 1'b1; abort = 1'b1;
    #1 chk("t5_abort_match", match, 0);
    settle();
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_cnt", match_cnt, 1);
    do_start();
    stream(16'b1001, 4, 16'b0001); settle();
    chk("t5_cfg_kept_cnt", match_cnt, 1);
    chk("t5_cfg_kept_busy", busy, 1);

    // len=1 free-run: counter wraps after 256 matches
    do_abort();
    cfg(4'b0001, 3'd1, 1'b0, 8'd0);
    do_start();
    tick(1'b0, 1'b1, 1'b0);
    repeat (257) tick(1'b1, 1'b1, 1'b1);
    settle();
    chk("wrap_cnt", match_cnt, 1);

    // Target of one finishes on the very first match
    do_abort();
    cfg(4'b0001, 3'd1, 1'b0, 8'd1);
    do_start();
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    settle();
    chk("tgt1_done", done, 1);
    chk("tgt1_cnt", match_cnt, 1);
    do_abort(); settle();
    chk("abort_done_idle", done, 0);

    // Eight valid zeros: watchdog fires only when compiled in
    cfg(4'b1001, 3'd4, 1'b0, 8'd0);
    do_start();
    repeat (8) tick(1'b0, 1'b1, 1'b0);
    settle();
    chk("t6_done", done, TMO_ON);
    chk("t6_busy", busy, !TMO_ON);
    chk("t6_timeout", timeout, TMO_ON);
`ifdef TIMEOUT_EN
    do_start(); settle();
    chk("t6_timeout_clr", timeout, 0);
    chk("t6_restart_busy", busy, 1);
`endif
    stream(16'b1001, 4, 16'b0001); settle();
    chk("t6_pre_rst_cnt", match_cnt, 1);

    // Reset mid-run clears everything including config
    @(posedge clk); #1;
    clr(); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_cnt", match_cnt, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_timeout", timeout, 0);
    chk("mrst_match", match, 0);
    do_start(); settle();
    chk("mrst_start_ignored", busy, 0);
    cfg(4'b1001, 3'd4, 1'b0, 8'd0);
    do_start(); settle();
    chk("mrst_start_ok", busy, 1);

    settle();
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
